// File: rtl/spi_slave_port_if.sv
// CPU-side register bus of the SPI slave port: select, address, strobes,
// write/read data and the interrupt line.
interface spi_slave_port_if;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n;
  logic        write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq;

  modport master (
    output spi_select, mem_addr, read_n, write_n, data_from_cpu,
    input  data_to_cpu, irq
  );

  modport slave (
    input  spi_select, mem_addr, read_n, write_n, data_from_cpu,
    output data_to_cpu, irq
  );
endinterface

// File: rtl/spi_slave_port.sv
// SPI mode-0, MSB-first, 8-bit slave. SCLK/MOSI/SS_n are oversampled in the
// clk domain (SYNC_STAGES must be at least 2). One-deep rx and tx buffers
// with status, sticky error flags and a maskable interrupt.
module spi_slave_port #(
  parameter logic [7:0] FILL_VALUE  = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            SCLK,
  input  logic            MOSI,
  input  logic            SS_n,
  output logic            MISO,
  output logic            MISO_oe,
  spi_slave_port_if.slave bus
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sclk_p0, mosi_p0, ss_p0;
  logic                   sclk_p1, ss_p1;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise, ss_act;

  logic       rd_prev, wr_prev, rd_act, wr_act, rd_strobe, wr_strobe;
  logic       rx_read, tx_write, stat_write, ctrl_write;

  logic [2:0] bitcnt;
  logic [7:0] rx_shift, tx_shift, rx_hold, tx_hold;
  logic       tx_primed, rrdy, roe, toe, tur;
  logic [5:0] ctrl;
  logic       byte_done, tx_load, tx_accept;
  logic [15:0] status_word, rd_mux;
  logic       unused_bus_bits;

  // Synchronizers plus one history flop; idle levels SCLK=0, MOSI=0, SS_n=1
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '1;
      sclk_p1   <= 1'b0;
      ss_p1     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
      sclk_p1   <= sclk_p0;
      ss_p1     <= ss_p0;
    end
  end

  assign sclk_p0   = sclk_sync[SYNC_STAGES-1];
  assign mosi_p0   = mosi_sync[SYNC_STAGES-1];
  assign ss_p0     = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_p0 & ~sclk_p1;
  assign sclk_fall = ~sclk_p0 & sclk_p1;
  assign ss_fall   = ~ss_p0 & ss_p1;
  assign ss_rise   = ss_p0 & ~ss_p1;
  assign ss_act    = ~ss_p0;

  // Bus strobes fire once, on the first cycle of each access
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
    end else begin
      rd_prev <= rd_act;
      wr_prev <= wr_act;
    end
  end

  assign rd_act     = bus.spi_select & ~bus.read_n;
  assign wr_act     = bus.spi_select & ~bus.write_n;
  assign rd_strobe  = rd_act & ~rd_prev;
  assign wr_strobe  = wr_act & ~wr_prev;
  assign rx_read    = rd_strobe & (bus.mem_addr == 3'd0);
  assign tx_write   = wr_strobe & (bus.mem_addr == 3'd1);
  assign stat_write = wr_strobe & (bus.mem_addr == 3'd2);
  assign ctrl_write = wr_strobe & (bus.mem_addr == 3'd3);

  // A byte completes on the 8th sampled rise; the next tx byte is loaded
  // then or on select fall. A tx write coinciding with a load still lands.
  assign byte_done = sclk_rise & ss_act & (bitcnt == 3'd7);
  assign tx_load   = ss_fall | byte_done;
  assign tx_accept = tx_write & (~tx_primed | tx_load);

  // Bit counter and shift registers; no shift on the fall that follows a
  // load so the freshly loaded bit 7 is presented for a full SCLK period
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt   <= 3'd0;
      rx_shift <= 8'h00;
      tx_shift <= 8'hFF;
    end else begin
      if (ss_fall || ss_rise)
        bitcnt <= 3'd0;
      else if (sclk_rise && ss_act)
        bitcnt <= bitcnt + 3'd1;
      if (sclk_rise && ss_act)
        rx_shift <= {rx_shift[6:0], mosi_p0};
      if (tx_load)
        tx_shift <= tx_primed ? tx_hold : FILL_VALUE;
      else if (sclk_fall && ss_act && bitcnt != 3'd0)
        tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  // Receive buffer and its flags; completion beats a same-cycle rx read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_hold <= 8'h00;
      rrdy    <= 1'b0;
      roe     <= 1'b0;
    end else begin
      if (byte_done)
        rx_hold <= {rx_shift[6:0], mosi_p0};
      if (byte_done)
        rrdy <= 1'b1;
      else if (rx_read)
        rrdy <= 1'b0;
      if (stat_write)
        roe <= 1'b0;
      else if (byte_done)
        roe <= rrdy & ~rx_read;
    end
  end

  // Transmit buffer, its flags and the control register; status write wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_hold   <= 8'h00;
      tx_primed <= 1'b0;
      toe       <= 1'b0;
      tur       <= 1'b0;
      ctrl      <= 6'd0;
    end else begin
      if (tx_accept)
        tx_hold <= bus.data_from_cpu[7:0];
      if (tx_accept)
        tx_primed <= 1'b1;
      else if (tx_load)
        tx_primed <= 1'b0;
      if (stat_write)
        toe <= 1'b0;
      else if (tx_write && !tx_accept)
        toe <= 1'b1;
      if (stat_write)
        tur <= 1'b0;
      else if (tx_load)
        tur <= ~tx_primed;
      if (ctrl_write)
        ctrl <= bus.data_from_cpu[8:3];
    end
  end

  assign status_word = {6'd0, ss_act, roe | toe | tur, rrdy, ~tx_primed,
                        tur, toe, roe, 3'd0};

  // Register read multiplexer
  always_comb begin
    rd_mux = 16'h0000;
    case (bus.mem_addr)
      3'd0:    rd_mux = {8'h00, rx_hold};
      3'd2:    rd_mux = status_word;
      3'd3:    rd_mux = {7'd0, ctrl, 3'd0};
      default: rd_mux = 16'h0000;
    endcase
  end

  // Registered read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.data_to_cpu <= 16'h0000;
      bus.irq         <= 1'b0;
    end else begin
      bus.data_to_cpu <= rd_mux;
      bus.irq         <= |(status_word[8:3] & ctrl);
    end
  end

  assign MISO            = tx_shift[7];
  assign MISO_oe         = ss_act;
  assign unused_bus_bits = ^bus.data_from_cpu[15:9];

endmodule

// File: tb/tb_spi_slave_port.sv
// Bench for spi_slave_port: acts as SPI master (mode 0, clk/16) and CPU.
module tb_spi_slave_port;
  localparam int HP = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic SCLK = 1'b0;
  logic MOSI = 1'b0;
  logic SS_n = 1'b1;
  logic MISO, MISO_oe;

  spi_slave_port_if bus();

  spi_slave_port #(.FILL_VALUE(8'hFF), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO), .MISO_oe(MISO_oe), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model of the peripheral
  logic [7:0] m_rx, m_hold, m_cur;
  bit         m_primed, m_rrdy, m_roe, m_toe, m_tur, m_ss;
  logic [5:0] m_ctrl;

  typedef struct packed {
    bit         do_wr;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
    logic [15:0] exp_stat;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic m_reset();
    m_rx = 8'h00; m_hold = 8'h00; m_cur = 8'hFF;
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0; m_ss = 0;
    m_ctrl = 6'd0;
  endtask

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = 16'h0000;
    s[3] = m_roe;
    s[4] = m_toe;
    s[5] = m_tur;
    s[6] = !m_primed;
    s[7] = m_rrdy;
    s[8] = m_roe | m_toe | m_tur;
    s[9] = m_ss;
    return s;
  endfunction

  function automatic logic m_irq();
    logic [15:0] s;
    s = m_status();
    return |(s[8:3] & m_ctrl);
  endfunction

  task automatic m_load(output logic [7:0] v);
    v = m_primed ? m_hold : 8'hFF;
    m_tur = !m_primed;
    m_primed = 0;
  endtask

  task automatic m_complete(input logic [7:0] mo);
    m_roe = m_rrdy;
    m_rrdy = 1;
    m_rx = mo;
    m_load(m_cur);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    bus.spi_select = 1'b1; bus.mem_addr = a; bus.data_from_cpu = d; bus.write_n = 1'b0;
    wait_clks(2);
    bus.spi_select = 1'b0; bus.write_n = 1'b1;
    wait_clks(1);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    bus.spi_select = 1'b1; bus.mem_addr = a; bus.read_n = 1'b0;
    wait_clks(1);
    d = bus.data_to_cpu;
    wait_clks(1);
    bus.spi_select = 1'b0; bus.read_n = 1'b1;
    wait_clks(1);
  endtask

  task automatic do_tx_write(input logic [7:0] v);
    logic [15:0] r;
    r = 16'($urandom);
    bus_write(3'd1, {r[15:8], v});
    if (!m_primed) begin
      m_hold = v; m_primed = 1;
    end else m_toe = 1;
  endtask

  task automatic do_stat_clear();
    bus_write(3'd2, 16'($urandom));
    m_roe = 0; m_toe = 0; m_tur = 0;
  endtask

  task automatic do_ctrl(input logic [5:0] c);
    logic [15:0] r;
    r = 16'($urandom);
    bus_write(3'd3, {r[15:9], c, r[2:0]});
    m_ctrl = c;
  endtask

  task automatic check_status(input string nm);
    logic [15:0] d;
    bus_read(3'd2, d);
    chk(nm, 32'(d), 32'(m_status()));
    chk({nm, "_irq"}, 32'(bus.irq), 32'(m_irq()));
  endtask

  task automatic check_rx(input string nm, output logic [7:0] got);
    logic [15:0] d;
    bus_read(3'd0, d);
    chk(nm, 32'(d), 32'({8'h00, m_rx}));
    got = d[7:0];
    m_rrdy = 0;
  endtask

  task automatic ss_begin();
    SS_n = 1'b0;
    wait_clks(HP);
    m_ss = 1;
    m_load(m_cur);
    chk("oe_on", 32'(MISO_oe), 32'd1);
  endtask

  task automatic ss_end();
    wait_clks(HP);
    SS_n = 1'b1;
    wait_clks(HP);
    m_ss = 0;
    chk("oe_off", 32'(MISO_oe), 32'd0);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit mid_wr,
                          input logic [7:0] mid_val, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      wait_clks(HP);
      mi = {mi[6:0], MISO};
      SCLK = 1'b1;
      wait_clks(HP);
      SCLK = 1'b0;
      if (mid_wr && i == 3) do_tx_write(mid_val);
    end
  endtask

  task automatic full_byte(input logic [7:0] mo, input bit mid_wr, input logic [7:0] mid_val,
                           output logic [7:0] mi);
    spi_bits(mo, 8, mid_wr, mid_val, mi);
    chk("miso_byte", 32'(mi), 32'(m_cur));
    m_complete(mo);
  endtask

  initial begin
    #900us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    logic [7:0]  mi, got;
    int nb;

    bus.spi_select = 1'b0; bus.mem_addr = 3'd0; bus.read_n = 1'b1;
    bus.write_n = 1'b1; bus.data_from_cpu = 16'h0000;
    m_reset();

    tbl[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 16'h0160};
    tbl[1] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 16'h0160};
    tbl[2] = '{1'b0, 8'h00, 8'h55, 8'hFF, 8'h55, 16'h0160};
    tbl[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E, 16'h0160};

    // reset state
    wait_clks(4);
    chk("rst_oe", 32'(MISO_oe), 32'd0);
    chk("rst_miso", 32'(MISO), 32'd1);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_rdata", 32'(bus.data_to_cpu), 32'd0);
    reset_n = 1'b1;
    wait_clks(4);
    bus_read(3'd2, d); chk("rst_status", 32'(d), 32'h0040);
    bus_read(3'd3, d); chk("rst_ctrl", 32'(d), 32'h0000);
    bus_read(3'd5, d); chk("addr5_zero", 32'(d), 32'h0000);

    // table-driven single-byte windows
    for (int v = 0; v < 4; v++) begin
      if (tbl[v].do_wr) do_tx_write(tbl[v].tx);
      ss_begin();
      spi_bits(tbl[v].mosi, 8, 1'b0, 8'h00, mi);
      chk("tbl_miso", 32'(mi), 32'(tbl[v].exp_miso));
      m_complete(tbl[v].mosi);
      ss_end();
      bus_read(3'd0, d); chk("tbl_rx", 32'(d), 32'(tbl[v].exp_rx));
      m_rrdy = 0;
      bus_read(3'd2, d); chk("tbl_status", 32'(d), 32'(tbl[v].exp_stat));
      do_stat_clear();
    end

    // back-to-back bytes in one window, second tx written mid-first-byte
    do_tx_write(8'h81);
    ss_begin();
    full_byte(8'h11, 1'b1, 8'h7E, mi);
    chk("b2b_miso0", 32'(mi), 32'h81);
    check_rx("b2b_rx0", got);
    chk("b2b_rx0_val", 32'(got), 32'h11);
    full_byte(8'h22, 1'b0, 8'h00, mi);
    chk("b2b_miso1", 32'(mi), 32'h7E);
    ss_end();
    check_rx("b2b_rx1", got);
    chk("b2b_rx1_val", 32'(got), 32'h22);
    bus_read(3'd2, d);
    chk("b2b_no_roe", 32'(d[3]), 32'd0);

    // underrun with TUR interrupt enabled
    do_stat_clear();
    do_ctrl(6'b000100);
    ss_begin();
    full_byte(8'h55, 1'b0, 8'h00, mi);
    chk("tur_miso", 32'(mi), 32'hFF);
    ss_end();
    check_status("tur_status");
    chk("tur_irq_on", 32'(bus.irq), 32'd1);
    do_stat_clear();
    chk("tur_irq_off", 32'(bus.irq), 32'd0);
    check_rx("tur_rx", got);
    do_ctrl(6'd0);

    // rx overrun, then tx write-while-full
    ss_begin();
    full_byte(8'hA1, 1'b0, 8'h00, mi);
    full_byte(8'hB2, 1'b0, 8'h00, mi);
    ss_end();
    bus_read(3'd2, d);
    chk("roe_set", 32'(d[3]), 32'd1);
    check_rx("roe_rx", got);
    chk("roe_rx_val", 32'(got), 32'hB2);
    do_stat_clear();
    do_tx_write(8'hC3);
    do_tx_write(8'hD4);
    check_status("toe_status");
    ss_begin();
    full_byte(8'h00, 1'b0, 8'h00, mi);
    chk("toe_keeps_first", 32'(mi), 32'hC3);
    ss_end();
    check_rx("toe_rx", got);

    // aborted partial byte, then a clean byte
    do_stat_clear();
    ss_begin();
    spi_bits(8'hF0, 5, 1'b0, 8'h00, mi);
    ss_end();
    bus_read(3'd2, d);
    chk("partial_no_rrdy", 32'(d[7]), 32'd0);
    ss_begin();
    full_byte(8'h5A, 1'b0, 8'h00, mi);
    ss_end();
    check_rx("partial_next_rx", got);
    chk("partial_next_val", 32'(got), 32'h5A);

    // randomized windows against the model
    for (int w = 0; w < 30; w++) begin
      nb = $urandom_range(0, 2);
      for (int k = 0; k < nb; k++) do_tx_write(8'($urandom));
      if ($urandom_range(0, 3) == 0) do_ctrl(6'($urandom));
      if ($urandom_range(0, 3) == 0) do_stat_clear();
      ss_begin();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        full_byte(8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom), mi);
        if ($urandom_range(0, 1) == 1) check_rx("rnd_rx", got);
        if ($urandom_range(0, 2) == 0) check_status("rnd_status_act");
      end
      ss_end();
      check_status("rnd_status");
    end

    // reset asserted mid-byte
    do_ctrl(6'b001000);
    check_status("pre_rst_status");
    ss_begin();
    spi_bits(8'hAA, 4, 1'b0, 8'h00, mi);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_oe", 32'(MISO_oe), 32'd0);
    chk("mid_rst_miso", 32'(MISO), 32'd1);
    chk("mid_rst_irq", 32'(bus.irq), 32'd0);
    chk("mid_rst_rdata", 32'(bus.data_to_cpu), 32'd0);
    @(negedge clk);
    SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wait_clks(2);
    reset_n = 1'b1;
    m_reset();
    wait_clks(4);
    bus_read(3'd2, d); chk("post_rst_status", 32'(d), 32'h0040);
    bus_read(3'd3, d); chk("post_rst_ctrl", 32'(d), 32'h0000);
    bus_read(3'd0, d); chk("post_rst_rx", 32'(d), 32'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
